mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder_pkg.sv | 31 +++
 rtl/io_byte_fifo.sv | 41 ++++
 rtl/mem_io_responder.sv | 102 ++++++++++
 tb/tb_mem_io_responder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the CPU memory/I-O responder: I/O address map,
// access classification and small byte-lane helpers.
package mem_io_responder_pkg;

  localparam int          IO_DEC_W      = 18;
  localparam logic [17:0] IO_SPACE_MASK = 18'h30000;
  localparam logic [17:0] IO_RXTX_ADDR  = 18'h30000;
  localparam logic [17:0] IO_CNT_ADDR   = 18'h30004;

  typedef enum logic [2:0] {
    ACC_RAM,
    ACC_RXTX,
    ACC_CNT,
    ACC_SNAP,
    ACC_IO_OTHER
  } acc_e;

  function automatic acc_e decode_acc(input logic [IO_DEC_W-1:0] a);
    if ((a & IO_SPACE_MASK) != IO_SPACE_MASK) return ACC_RAM;
    if (a == IO_RXTX_ADDR) return ACC_RXTX;
    if (a == IO_CNT_ADDR) return ACC_CNT;
    // 0x30005..0x30007 share the counter word with 0x30004
    if (a[IO_DEC_W-1:2] == IO_CNT_ADDR[IO_DEC_W-1:2]) return ACC_SNAP;
    return ACC_IO_OTHER;
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/io_byte_fifo.sv
// Byte FIFO feeding the TX stream; head reads as 0x00 while empty.
module io_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]  mem_reg [DEPTH];
  logic [PW:0] wr_ptr_reg;
  logic [PW:0] rd_ptr_reg;

  // Extra pointer bit distinguishes full from empty when indices coincide
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                 (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign head  = empty ? 8'h00 : mem_reg[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk_in) begin
    if (push && !full) mem_reg[wr_ptr_reg[PW-1:0]] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU bus responder: byte RAM plus memory-mapped RX/TX streams, a free-running
// cycle counter with snapshot, and a sticky program-stop flag.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_done
);

  logic [7:0]  ram [0:(2**RAM_AW)-1];
  logic [7:0]  ram_q_reg;
  logic [7:0]  io_q_reg;
  logic        sel_ram_reg;
  logic [31:0] counter_reg;
  logic [31:0] snap_reg;
  logic        prog_done_reg;

  acc_e        acc;
  logic        rd_rx, push_req, stall, accept;
  logic        push, pop, fifo_full, fifo_empty;
  logic [7:0]  push_data, io_rd_data;
  logic        ram_wr_en, ram_rd_en;
  logic        unused_addr_hi;

  assign acc            = decode_acc(mem_a[IO_DEC_W-1:0]);
  assign unused_addr_hi = ^mem_a[31:IO_DEC_W];

  always_comb begin
    rd_rx     = (acc == ACC_RXTX) && !mem_wr;
    push_req  = mem_wr && (((acc == ACC_RXTX) && (mem_dout != 8'h00)) || (acc == ACC_CNT));
    // Full is judged before any same-cycle pop, so a full queue always stalls one cycle
    stall     = (rd_rx && !rx_valid) || (push_req && fifo_full);
    accept    = rst_in && !stall;
    rdy_out   = !stall || !rst_in;
    rx_ready  = accept && rd_rx;
    push      = accept && push_req;
    push_data = (acc == ACC_CNT) ? 8'h00 : mem_dout;
    pop       = tx_valid && tx_ready;
    ram_wr_en = accept && mem_wr && (acc == ACC_RAM);
    ram_rd_en = accept && !mem_wr && (acc == ACC_RAM);
    case (acc)
      ACC_RXTX: io_rd_data = rx_data;
      ACC_CNT:  io_rd_data = counter_reg[7:0];
      ACC_SNAP: io_rd_data = word_byte(snap_reg, mem_a[1:0]);
      default:  io_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (ram_wr_en) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    if (ram_rd_en) ram_q_reg <= ram[mem_a[RAM_AW-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      io_q_reg      <= 8'h00;
      sel_ram_reg   <= 1'b0;
      counter_reg   <= 32'h0;
      snap_reg      <= 32'h0;
      prog_done_reg <= 1'b0;
    end else begin
      counter_reg <= counter_reg + 32'h1;
      if (accept && !mem_wr) begin
        sel_ram_reg <= (acc == ACC_RAM);
        if (acc != ACC_RAM) io_q_reg <= io_rd_data;
        if (acc == ACC_CNT) snap_reg <= counter_reg;
      end
      if (accept && mem_wr && (acc == ACC_CNT)) prog_done_reg <= 1'b1;
    end
  end

  assign mem_din   = sel_ram_reg ? ram_q_reg : io_q_reg;
  assign prog_done = prog_done_reg;
  assign tx_valid  = !fifo_empty;

  io_byte_fifo #(.DEPTH(TXQ_DEPTH)) u_txq (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (tx_data)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: scenario tasks with randomized
// traffic compared against a queue/array reference model.
module tb_mem_io_responder;

  localparam int STALL_LIM = 200;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = 32'h3000C;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = 8'h00;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        prog_done;

  int n_checks = 0;
  int n_fail = 0;
  bit rand_ready = 0;

  logic [31:0] model_cnt = 32'h0;
  logic [7:0]  tx_seen[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  ram_model [logic [16:0]];

  mem_io_responder #(.RAM_AW(17), .TXQ_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din), .rdy_out(rdy_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prog_done(prog_done)
  );

  always #5 clk_in = ~clk_in;

  // Counter rule: zero at a reset edge, +1 at every other edge
  always @(posedge clk_in) model_cnt <= rst_in ? model_cnt + 32'h1 : 32'h0;

  always @(negedge clk_in) begin
    #3;
    if (rst_in && tx_valid && tx_ready) tx_seen.push_back(tx_data);
  end

  task automatic idle();
    mem_a = 32'h3000C; mem_wr = 1'b0; mem_dout = 8'h00; rx_valid = 1'b0;
  endtask

  // Presents one CPU request at a negedge, holds it through stalls, returns at the
  // negedge after the accepting edge with the bus idled.
  task automatic cpu_op(input logic [31:0] a, input logic w, input logic [7:0] d,
                        output int stalls, output logic [31:0] cnt_at);
    mem_a = a; mem_wr = w; mem_dout = d; stalls = 0;
    forever begin
      #1;
      if (rdy_out) break;
      @(negedge clk_in);
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      stalls++;
      if (stalls >= STALL_LIM) begin
        n_checks++; n_fail++;
        $display("FAIL op_timeout addr=%h stalls=%0d limit=%0d", a, stalls, STALL_LIM);
        break;
      end
    end
    cnt_at = model_cnt;
    @(negedge clk_in);
    idle();
  endtask

  task automatic test_reset();
    rst_in = 1'b0; mem_a = 32'h30000; mem_wr = 1'b0; rx_valid = 1'b1; rx_data = 8'h5A;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    #1;
    n_checks++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL reset_mem_din got=%h exp=00", mem_din); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    n_checks++; if (prog_done !== 1'b0) begin n_fail++; $display("FAIL reset_prog_done got=%b exp=0", prog_done); end
    n_checks++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_out got=%b exp=1", rdy_out); end
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
    @(negedge clk_in);
    idle(); rst_in = 1'b1;
    @(negedge clk_in);
    $display("reset: outputs checked, released");
  endtask

  task automatic test_ram_basic();
    int st; logic [31:0] c;
    cpu_op(32'h00010, 1'b1, 8'hA5, st, c);
    ram_model[17'h00010] = 8'hA5;
    cpu_op(32'h00010, 1'b0, 8'h00, st, c);
    n_checks++; if (mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_raw got=%h exp=a5", mem_din); end
    n_checks++; if (st != 0) begin n_fail++; $display("FAIL ram_stall got=%0d exp=0", st); end
    $display("ram_basic: wr 00010=a5 then rd -> %h", mem_din);
  endtask

  task automatic test_ram_random();
    logic [31:0] addrs[8];
    int st; logic [31:0] c;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = $urandom;
      if (addrs[i][17:16] == 2'b11) addrs[i][17] = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [16:0] idx;
      logic [7:0]  d;
      a = addrs[$urandom_range(0, 7)];
      idx = a[16:0];
      if (!ram_model.exists(idx) || ($urandom_range(0, 2) == 0)) begin
        d = 8'($urandom);
        cpu_op(a, 1'b1, d, st, c);
        ram_model[idx] = d;
        $display("ram_rand: wr %h=%h", a, d);
      end else begin
        cpu_op(a, 1'b0, 8'h00, st, c);
        n_checks++;
        if (mem_din !== ram_model[idx]) begin
          n_fail++; $display("FAIL ram_rand_rd addr=%h got=%h exp=%h", a, mem_din, ram_model[idx]);
        end
        $display("ram_rand: rd %h -> %h", a, mem_din);
      end
    end
  endtask

  task automatic test_rx_stall();
    int st; logic [31:0] c; logic [7:0] held, b;
    cpu_op(32'h00010, 1'b0, 8'h00, st, c);
    held = ram_model[17'h00010];
    mem_a = 32'h30000; mem_wr = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (rdy_out !== 1'b0 || rx_ready !== 1'b0) begin
        n_fail++; $display("FAIL rx_stall cyc=%0d rdy=%b rx_ready=%b exp=0/0", i, rdy_out, rx_ready);
      end
      @(negedge clk_in);
      n_checks++; if (mem_din !== held) begin n_fail++; $display("FAIL rx_hold got=%h exp=%h", mem_din, held); end
    end
    rx_data = 8'h41; rx_valid = 1'b1;
    #1;
    n_checks++; if (rdy_out !== 1'b1 || rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL rx_accept rdy=%b rx_ready=%b exp=1/1", rdy_out, rx_ready);
    end
    @(negedge clk_in);
    idle();
    #1;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_once got=%b exp=0", rx_ready); end
    n_checks++; if (mem_din !== 8'h41) begin n_fail++; $display("FAIL rx_data got=%h exp=41", mem_din); end
    $display("rx_stall: 5 stall cycles then byte %h", mem_din);
    @(negedge clk_in);
    for (int i = 0; i < 6; i++) begin
      int g;
      g = $urandom_range(0, 3);
      b = 8'($urandom);
      mem_a = 32'h30000; mem_wr = 1'b0; rx_valid = 1'b0;
      repeat (g) @(negedge clk_in);
      rx_data = b; rx_valid = 1'b1;
      cpu_op({14'($urandom), 18'h30000}, 1'b0, 8'h00, st, c);
      n_checks++; if (mem_din !== b || st != 0) begin
        n_fail++; $display("FAIL rx_rand got=%h exp=%h stalls=%0d", mem_din, b, st);
      end
      $display("rx_rand: gap=%0d byte %h", g, mem_din);
    end
  endtask

  task automatic check_tx_stream(input string name);
    n_checks++;
    if (tx_seen.size() != exp_tx.size()) begin
      n_fail++; $display("FAIL %s_len got=%0d exp=%0d", name, tx_seen.size(), exp_tx.size());
    end else begin
      for (int i = 0; i < exp_tx.size(); i++) begin
        n_checks++;
        if (tx_seen[i] !== exp_tx[i]) begin
          n_fail++; $display("FAIL %s_byte%0d got=%h exp=%h", name, i, tx_seen[i], exp_tx[i]);
        end
      end
    end
    $display("%s: %0d bytes streamed", name, tx_seen.size());
  endtask

  task automatic test_tx_basic();
    int st; logic [31:0] c;
    logic [7:0] seq[3];
    seq[0] = 8'h48; seq[1] = 8'h00; seq[2] = 8'h69;
    tx_ready = 1'b1; tx_seen.delete(); exp_tx.delete();
    for (int i = 0; i < 3; i++) begin
      cpu_op(32'h30000, 1'b1, seq[i], st, c);
      if (seq[i] != 8'h00) exp_tx.push_back(seq[i]);
      n_checks++; if (st != 0) begin n_fail++; $display("FAIL tx_basic_stall got=%0d exp=0", st); end
    end
    repeat (4) @(negedge clk_in);
    check_tx_stream("tx_basic");
  endtask

  task automatic test_tx_full();
    int st; logic [31:0] c;
    tx_ready = 1'b0; tx_seen.delete(); exp_tx.delete();
    for (int i = 0; i < 8; i++) begin
      cpu_op(32'h30000, 1'b1, 8'h10 + 8'(i), st, c);
      exp_tx.push_back(8'h10 + 8'(i));
      n_checks++; if (st != 0) begin n_fail++; $display("FAIL tx_fill_stall i=%0d got=%0d exp=0", i, st); end
    end
    cpu_op(32'h30010, 1'b1, 8'h55, st, c);
    n_checks++; if (st != 0) begin n_fail++; $display("FAIL other_io_wr_stall got=%0d exp=0", st); end
    cpu_op(32'h30000, 1'b1, 8'h00, st, c);
    n_checks++; if (st != 0) begin n_fail++; $display("FAIL zero_wr_full_stall got=%0d exp=0", st); end
    cpu_op(32'h30001, 1'b0, 8'h00, st, c);
    n_checks++; if (mem_din !== 8'h00 || st != 0) begin
      n_fail++; $display("FAIL other_io_rd got=%h stalls=%0d exp=00/0", mem_din, st);
    end
    mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (rdy_out !== 1'b0) begin n_fail++; $display("FAIL tx_full_rdy cyc=%0d got=%b exp=0", i, rdy_out); end
      @(negedge clk_in);
    end
    tx_ready = 1'b1;
    #1;
    n_checks++; if (rdy_out !== 1'b0) begin n_fail++; $display("FAIL tx_full_prepop got=%b exp=0", rdy_out); end
    @(negedge clk_in);
    #1;
    n_checks++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL tx_slot_free got=%b exp=1", rdy_out); end
    exp_tx.push_back(8'h99);
    @(negedge clk_in);
    idle();
    repeat (12) @(negedge clk_in);
    check_tx_stream("tx_full");
  endtask

  task automatic test_tx_random();
    int st; logic [31:0] c;
    tx_seen.delete(); exp_tx.delete(); rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      int k; logic [7:0] d;
      k = $urandom_range(0, 3);
      d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      tx_ready = 1'($urandom_range(0, 1));
      if (k == 3) begin
        cpu_op({14'($urandom), 18'h30008 + 18'($urandom_range(0, 255))}, 1'b1, d, st, c);
        $display("tx_rand: other io wr %h stalls=%0d", d, st);
      end else begin
        cpu_op({14'($urandom), 18'h30000}, 1'b1, d, st, c);
        if (d != 8'h00) exp_tx.push_back(d);
        $display("tx_rand: wr %h stalls=%0d", d, st);
      end
    end
    rand_ready = 0; tx_ready = 1'b1;
    repeat (20) @(negedge clk_in);
    check_tx_stream("tx_rand");
  endtask

  task automatic test_counter();
    int st; logic [31:0] c, c2;
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk_in);
      cpu_op({14'($urandom), 18'h30004}, 1'b0, 8'h00, st, c);
      n_checks++; if (mem_din !== c[7:0]) begin n_fail++; $display("FAIL cnt_b0 got=%h exp=%h", mem_din, c[7:0]); end
      for (int b = 1; b < 4; b++) begin
        logic [7:0] e;
        e = 8'(c >> (8 * b));
        cpu_op(32'h30004 + 32'(b), 1'b0, 8'h00, st, c2);
        n_checks++; if (mem_din !== e) begin n_fail++; $display("FAIL cnt_b%0d got=%h exp=%h", b, mem_din, e); end
      end
      repeat (300) @(negedge clk_in);
      cpu_op(32'h30005, 1'b0, 8'h00, st, c2);
      n_checks++; if (mem_din !== c[15:8]) begin n_fail++; $display("FAIL snap_hold got=%h exp=%h", mem_din, c[15:8]); end
      $display("counter: snapshot %h, byte1 re-read %h", c, mem_din);
    end
  endtask

  task automatic test_prog_done();
    int st; logic [31:0] c;
    tx_ready = 1'b1; tx_seen.delete(); exp_tx.delete();
    #1;
    n_checks++; if (prog_done !== 1'b0) begin n_fail++; $display("FAIL prog_done_init got=%b exp=0", prog_done); end
    cpu_op(32'h30004, 1'b1, 8'h77, st, c);
    exp_tx.push_back(8'h00);
    n_checks++; if (prog_done !== 1'b1) begin n_fail++; $display("FAIL prog_done_set got=%b exp=1", prog_done); end
    cpu_op(32'h30000, 1'b1, 8'h33, st, c);
    exp_tx.push_back(8'h33);
    repeat (4) @(negedge clk_in);
    n_checks++; if (prog_done !== 1'b1) begin n_fail++; $display("FAIL prog_done_sticky got=%b exp=1", prog_done); end
    check_tx_stream("prog_stop");
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) cpu_op(32'h30000, 1'b1, 8'hC0 + 8'(i), st, c);
    mem_a = 32'h30000; mem_wr = 1'b0; rx_valid = 1'b0;
    #1;
    n_checks++; if (rdy_out !== 1'b0) begin n_fail++; $display("FAIL pre_reset_stall got=%b exp=0", rdy_out); end
    @(negedge clk_in);
    rst_in = 1'b0; rx_valid = 1'b1;
    #1;
    n_checks++; if (rdy_out !== 1'b1 || rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL in_reset rdy=%b rx_ready=%b exp=1/0", rdy_out, rx_ready);
    end
    @(negedge clk_in);
    #1;
    n_checks++; if (prog_done !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || mem_din !== 8'h00) begin
      n_fail++; $display("FAIL post_reset prog_done=%b tx_valid=%b tx_data=%h mem_din=%h exp=0/0/00/00",
                         prog_done, tx_valid, tx_data, mem_din);
    end
    idle(); rst_in = 1'b1; tx_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_discard got=%b exp=0", tx_valid); end
    cpu_op(32'h30004, 1'b0, 8'h00, st, c);
    n_checks++; if (mem_din !== c[7:0]) begin n_fail++; $display("FAIL cnt_restart got=%h exp=%h", mem_din, c[7:0]); end
    $display("prog_done: set, sticky, cleared by reset; counter restarted at %h", c);
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_ram_random();
    test_rx_stall();
    test_tx_basic();
    test_tx_full();
    test_tx_random();
    test_counter();
    test_prog_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
